// File: rtl/param_shift_ser_if.sv
// Bundle of control, data and status signals for the parameterised shift register / serializer.
interface param_shift_ser_if #(
  parameter int unsigned WIDTH = 8
);
  logic             en;
  logic [1:0]       mode;
  logic             ld;
  logic             start;
  logic             s_in;
  logic [WIDTH-1:0] p_in;
  logic [WIDTH-1:0] q;
  logic             s_out;
  logic             busy;
  logic             done;

  modport master (
    output en, mode, ld, start, s_in, p_in,
    input  q, s_out, busy, done
  );

  modport slave (
    input  en, mode, ld, start, s_in, p_in,
    output q, s_out, busy, done
  );
endinterface

// File: rtl/param_shift_ser.sv
// Shift register with manual shift/rotate ops and a WIDTH-beat serializer.
// Serial tap sits at the MSB (MSB_FIRST=1) or the LSB (MSB_FIRST=0).
module param_shift_ser #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1
) (
  input logic              clk,
  input logic              rst_n,
  param_shift_ser_if.slave bus
);
  localparam int unsigned CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] q_r;
  logic             busy_r;
  logic             done_r;
  logic [WIDTH-1:0] tap_shift;

  // Serializer shift moves data toward the tap, filling from the far end.
  assign tap_shift = MSB_FIRST ? {q_r[WIDTH-2:0], bus.s_in}
                               : {bus.s_in, q_r[WIDTH-1:1]};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      q_r    <= '0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      done_r <= 1'b0;
      if (bus.ld) begin
        q_r    <= bus.p_in;
        state  <= IDLE;
        cnt    <= '0;
        busy_r <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (bus.start) begin
              q_r    <= bus.p_in;
              cnt    <= '0;
              state  <= SHIFT;
              busy_r <= 1'b1;
            end else if (bus.en) begin
              case (bus.mode)
                2'b01:   q_r <= {bus.s_in, q_r[WIDTH-1:1]};
                2'b10:   q_r <= {q_r[WIDTH-2:0], bus.s_in};
                2'b11:   q_r <= {q_r[0], q_r[WIDTH-1:1]};
                default: q_r <= q_r;
              endcase
            end
          end
          SHIFT: begin
            if (bus.en) begin
              q_r <= tap_shift;
              // Last beat: return to IDLE and flag completion next cycle.
              if (cnt == CW'(WIDTH - 1)) begin
                cnt    <= '0;
                state  <= IDLE;
                busy_r <= 1'b0;
                done_r <= 1'b1;
              end else begin
                cnt <= cnt + CW'(1);
              end
            end
          end
          default: begin
            state  <= IDLE;
            cnt    <= '0;
            busy_r <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.q     = q_r;
  assign bus.busy  = busy_r;
  assign bus.done  = done_r;
  assign bus.s_out = MSB_FIRST ? q_r[WIDTH-1] : q_r[0];
endmodule

// File: tb/tb_param_shift_ser.sv
// Self-checking bench: directed scenarios plus randomized traffic against a beat-level model.
module tb_param_shift_ser;
  logic clk;
  logic rst_n;

  param_shift_ser_if #(.WIDTH(8)) if8 ();
  param_shift_ser_if #(.WIDTH(4)) if4 ();

  param_shift_ser #(.WIDTH(8), .MSB_FIRST(1'b1)) dut8 (.clk(clk), .rst_n(rst_n), .bus(if8));
  param_shift_ser #(.WIDTH(4), .MSB_FIRST(1'b0)) dut4 (.clk(clk), .rst_n(rst_n), .bus(if4));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int fails     = 0;

  // Reference model for the 8-bit MSB-first instance: beats remaining instead of a counter.
  logic [7:0] m_q;
  logic       m_busy;
  logic       m_done;
  int         m_left;

  task automatic model_reset();
    m_q = 8'h00; m_busy = 1'b0; m_done = 1'b0; m_left = 0;
  endtask

  // Advance one clock; model consumes the inputs that were present at the edge.
  task automatic tick();
    logic       c_ld, c_start, c_en, c_s_in;
    logic [1:0] c_mode;
    logic [7:0] c_p;
    c_ld = if8.ld; c_start = if8.start; c_en = if8.en;
    c_s_in = if8.s_in; c_mode = if8.mode; c_p = if8.p_in;
    @(posedge clk);
    #1;
    if (rst_n) begin
      m_done = 1'b0;
      if (c_ld) begin
        m_q = c_p; m_busy = 1'b0; m_left = 0;
      end else if (!m_busy) begin
        if (c_start) begin
          m_q = c_p; m_busy = 1'b1; m_left = 8;
        end else if (c_en) begin
          case (c_mode)
            2'd1: m_q = (m_q >> 1) | (8'(c_s_in) << 7);
            2'd2: m_q = 8'((m_q << 1) | 8'(c_s_in));
            2'd3: m_q = (m_q >> 1) | (8'(m_q & 8'h01) << 7);
            default: ;
          endcase
        end
      end else if (c_en) begin
        m_q = 8'((m_q << 1) | 8'(c_s_in));
        m_left = m_left - 1;
        if (m_left == 0) begin
          m_busy = 1'b0; m_done = 1'b1;
        end
      end
    end
  endtask

  task automatic idle_inputs();
    if8.ld = 0; if8.start = 0; if8.en = 0; if8.mode = 2'b00; if8.s_in = 0; if8.p_in = 8'h00;
    if4.ld = 0; if4.start = 0; if4.en = 0; if4.mode = 2'b00; if4.s_in = 0; if4.p_in = 4'h0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst_n = 1'b0;
    model_reset();
    #3;
    tests_run++;
    if ({if8.q, if8.busy, if8.done, if8.s_out} !== {8'h00, 3'b000}) begin
      fails++;
      $display("FAIL reset8: got q=%h busy=%b done=%b s_out=%b, want 00/0/0/0",
               if8.q, if8.busy, if8.done, if8.s_out);
    end
    tests_run++;
    if ({if4.q, if4.busy, if4.done, if4.s_out} !== {4'h0, 3'b000}) begin
      fails++;
      $display("FAIL reset4: got q=%h busy=%b done=%b s_out=%b, want 0/0/0/0",
               if4.q, if4.busy, if4.done, if4.s_out);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    tests_run++;
    if ({if8.q, if8.busy, if8.done} !== {8'h00, 2'b00}) begin
      fails++;
      $display("FAIL reset_release: got q=%h busy=%b done=%b, want 00/0/0", if8.q, if8.busy, if8.done);
    end
  endtask

  task automatic test_manual_ops();
    if8.ld = 1; if8.p_in = 8'hA5;
    tick();
    if8.ld = 0;
    tests_run++;
    if (if8.q !== 8'hA5) begin fails++; $display("FAIL manual_load: got %h want a5", if8.q); end
    if8.mode = 2'b01; if8.s_in = 1; if8.en = 1;
    tick();
    tests_run++;
    if (if8.q !== 8'hD2) begin fails++; $display("FAIL manual_shr: got %h want d2", if8.q); end
    if8.mode = 2'b11;
    tick();
    tests_run++;
    if (if8.q !== 8'h69) begin fails++; $display("FAIL manual_ror: got %h want 69", if8.q); end
    if8.mode = 2'b00;
    tick();
    tests_run++;
    if (if8.q !== 8'h69) begin fails++; $display("FAIL manual_hold: got %h want 69", if8.q); end
    if8.mode = 2'b10; if8.en = 0;
    tick();
    tests_run++;
    if (if8.q !== 8'h69) begin fails++; $display("FAIL manual_en_off: got %h want 69", if8.q); end
    if8.en = 1; if8.s_in = 0;
    tick();
    if8.en = 0; if8.mode = 2'b00;
    tests_run++;
    if (if8.q !== 8'hD2 || if8.busy !== 1'b0) begin
      fails++; $display("FAIL manual_shl: got q=%h busy=%b want d2/0", if8.q, if8.busy);
    end
  endtask

  task automatic test_serialize();
    logic [7:0] seq;
    seq = 8'b1100_0011;
    if8.start = 1; if8.p_in = 8'hC3; if8.s_in = 0;
    tick();
    if8.start = 0; if8.en = 1; if8.p_in = 8'h00;
    for (int k = 0; k < 8; k++) begin
      tests_run++;
      if (if8.busy !== 1'b1 || if8.s_out !== seq[7-k] || if8.done !== 1'b0) begin
        fails++;
        $display("FAIL ser_bit%0d: got busy=%b s_out=%b done=%b want 1/%b/0",
                 k, if8.busy, if8.s_out, if8.done, seq[7-k]);
      end
      tick();
    end
    if8.en = 0;
    tests_run++;
    if (if8.busy !== 1'b0 || if8.done !== 1'b1 || if8.q !== 8'h00) begin
      fails++;
      $display("FAIL ser_end: got busy=%b done=%b q=%h want 0/1/00", if8.busy, if8.done, if8.q);
    end
    tick();
    tests_run++;
    if (if8.done !== 1'b0) begin fails++; $display("FAIL ser_done_pulse: got %b want 0", if8.done); end
  endtask

  task automatic test_stall();
    logic [7:0] seq;
    int         bad;
    seq = 8'b1100_0011;
    bad = 0;
    if8.start = 1; if8.p_in = 8'hC3; if8.s_in = 0;
    tick();
    if8.start = 0;
    for (int c = 0; c < 16; c++) begin
      if8.en = (c % 2 == 1);
      if (if8.busy !== 1'b1 || if8.s_out !== seq[7 - c/2] || if8.done !== 1'b0) bad++;
      tick();
    end
    if8.en = 0;
    tests_run++;
    if (bad != 0) begin fails++; $display("FAIL stall_bits: got %0d bad cycles want 0", bad); end
    tests_run++;
    if (if8.busy !== 1'b0 || if8.done !== 1'b1 || if8.q !== 8'h00) begin
      fails++;
      $display("FAIL stall_end: got busy=%b done=%b q=%h want 0/1/00", if8.busy, if8.done, if8.q);
    end
    tick();
    tests_run++;
    if (if8.done !== 1'b0) begin fails++; $display("FAIL stall_done_pulse: got %b want 0", if8.done); end
  endtask

  task automatic test_ld_abort();
    if8.start = 1; if8.p_in = 8'hC3; if8.s_in = 0;
    tick();
    if8.start = 0; if8.en = 1;
    for (int c = 0; c < 4; c++) begin
      if8.start = (c == 1);
      if8.ld    = (c == 3);
      if8.p_in  = (c == 3) ? 8'h0F : 8'h55;
      if (c == 2) begin
        tests_run++;
        if (if8.q !== 8'h0C || if8.busy !== 1'b1) begin
          fails++; $display("FAIL abort_start_ignored: got q=%h busy=%b want 0c/1", if8.q, if8.busy);
        end
      end
      tick();
    end
    if8.ld = 0; if8.start = 0; if8.en = 0;
    tests_run++;
    if (if8.q !== 8'h0F || if8.busy !== 1'b0 || if8.done !== 1'b0) begin
      fails++;
      $display("FAIL abort_ld: got q=%h busy=%b done=%b want 0f/0/0", if8.q, if8.busy, if8.done);
    end
    tick();
    tests_run++;
    if (if8.done !== 1'b0 || if8.q !== 8'h0F) begin
      fails++; $display("FAIL abort_no_done: got done=%b q=%h want 0/0f", if8.done, if8.q);
    end
  endtask

  task automatic test_lsb_first();
    logic [3:0] seq;
    seq = 4'b0110;
    if4.start = 1; if4.p_in = 4'b0110; if4.s_in = 1;
    tick();
    if4.start = 0; if4.en = 1;
    for (int k = 0; k < 4; k++) begin
      tests_run++;
      if (if4.busy !== 1'b1 || if4.s_out !== seq[k]) begin
        fails++;
        $display("FAIL lsb_bit%0d: got busy=%b s_out=%b want 1/%b", k, if4.busy, if4.s_out, seq[k]);
      end
      tick();
    end
    if4.en = 0; if4.s_in = 0;
    tests_run++;
    if (if4.q !== 4'hF || if4.done !== 1'b1 || if4.busy !== 1'b0) begin
      fails++;
      $display("FAIL lsb_end: got q=%h done=%b busy=%b want f/1/0", if4.q, if4.done, if4.busy);
    end
    tick();
    tests_run++;
    if (if4.done !== 1'b0) begin fails++; $display("FAIL lsb_done_pulse: got %b want 0", if4.done); end
  endtask

  task automatic test_reset_mid();
    if8.start = 1; if8.p_in = 8'hC3; if8.en = 1;
    tick();
    if8.start = 0;
    tick();
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    tests_run++;
    if ({if8.q, if8.busy, if8.done, if8.s_out} !== {8'h00, 3'b000}) begin
      fails++;
      $display("FAIL reset_async: got q=%h busy=%b done=%b s_out=%b want 00/0/0/0",
               if8.q, if8.busy, if8.done, if8.s_out);
    end
    #2;
    rst_n = 1'b1;
    if8.en = 0;
    for (int c = 0; c < 10; c++) begin
      if8.en = c[0];
      tick();
      tests_run++;
      if (if8.done !== 1'b0 || if8.busy !== 1'b0 || if8.q !== 8'h00) begin
        fails++;
        $display("FAIL reset_abort%0d: got done=%b busy=%b q=%h want 0/0/00", c, if8.done, if8.busy, if8.q);
      end
    end
    if8.en = 0;
  endtask

  task automatic test_random();
    int bad;
    bad = 0;
    for (int c = 0; c < 400; c++) begin
      if8.ld    = ($urandom_range(0, 24) == 0);
      if8.start = ($urandom_range(0, 7) == 0);
      if8.en    = ($urandom_range(0, 2) != 0);
      if8.mode  = 2'($urandom_range(0, 3));
      if8.s_in  = 1'($urandom_range(0, 1));
      if8.p_in  = 8'($urandom);
      tick();
      tests_run++;
      if ({if8.q, if8.busy, if8.done, if8.s_out} !== {m_q, m_busy, m_done, m_q[7]}) begin
        fails++;
        bad++;
        if (bad <= 5)
          $display("FAIL random_cyc%0d: got q=%h busy=%b done=%b s_out=%b want %h/%b/%b/%b",
                   c, if8.q, if8.busy, if8.done, if8.s_out, m_q, m_busy, m_done, m_q[7]);
      end
    end
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_manual_ops();
    test_serialize();
    test_stall();
    test_ld_abort();
    test_lsb_first();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, fails);
    $finish;
  end
endmodule
